ped_crossing_ctrl: RTL and testbench
====================================

Name: ped_crossing_ctrl

Overview:
Pedestrian signal controller that sits directly downstream of the intersection traffic-light FSM. It consumes that FSM's one-hot red/yellow/green outputs and drives walk / don't-walk lamps plus a countdown display. It also latches pedestrian button requests and serves them only inside a red phase. A non-one-hot light input forces a sticky safe fault state.

Parameters:
WALK_CYCLES, 8, clk cycles walk_o held high per served request (>=1)
FLASH_CYCLES, 6, clk cycles of flashing don't-walk after walk (>=1, < 2**CNT_W)
FLASH_HALF, 1, clk cycles per flash half-period (>=1)
CNT_W, 4, width of countdown_o and internal phase counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
red_i  in  1  vehicle red lamp from upstream light FSM
yellow_i  in  1  vehicle yellow lamp
green_i  in  1  vehicle green lamp
btn_i  in  1  pedestrian button, already synchronised to clk, level
walk_o  out  1  walk lamp
dont_walk_o  out  1  don't-walk lamp
req_pending_o  out  1  request latched, awaiting service
countdown_o  out  CNT_W  remaining flash cycles, 0 outside FLASH
fault_o  out  1  sticky illegal-light-input flag

Behaviour:
- All outputs registered. Reset values: walk_o=0, dont_walk_o=1, req_pending_o=0, countdown_o=0, fault_o=0, state=IDLE, red_q=0, btn_q=0.
- Edge detection: red_rise = red_i & ~red_q; btn_rise = btn_i & ~btn_q. red_q and btn_q are 1-cycle delayed copies.
- Legality check: lights_ok = exactly one of red_i, yellow_i, green_i high. Evaluated every cycle in every state.
- States: IDLE, WALK, FLASH, FAULT.
- IDLE: dont_walk_o=1, walk_o=0.
  - If red_rise & (req_pending | btn_rise), go to WALK next cycle, clear req_pending, load counter = WALK_CYCLES-1.
  - Latency: walk_o rises 1 cycle after the red_rise sample.
- WALK: walk_o=1, dont_walk_o=0, countdown_o=0.
  - Counter decrements each cycle. At 0, go to FLASH, load counter = FLASH_CYCLES-1, phase=on.
  - btn_rise in WALK is discarded (request is being served).
- FLASH: walk_o=0. dont_walk_o=1 for the first FLASH_HALF cycles, then toggles every FLASH_HALF cycles.
  - countdown_o = counter+1, so the first FLASH cycle shows FLASH_CYCLES and the last shows 1.
  - At counter 0, go to IDLE; dont_walk_o=1 solid and countdown_o=0 on that next cycle.
  - btn_rise in FLASH sets req_pending for the next red phase.
- Early red loss: red_i=0 while in WALK or FLASH forces IDLE on the next cycle (dont_walk_o=1, walk_o=0, countdown_o=0). The aborted request is not re-latched.
- Request latch: btn_rise in IDLE (not consumed by a same-cycle red_rise), FLASH, or during red without a red edge sets req_pending. It holds until a WALK entry clears it.
- Simultaneous btn_rise and red_rise in IDLE: served immediately; req_pending stays 0.
- FAULT: entered from any state when !lights_ok.
  - Outputs: walk_o=0, dont_walk_o=1, countdown_o=0, fault_o=1.
  - Sticky until rst_n. Input returning to legal does not exit. Requests are ignored and req_pending is cleared.
  - The fault check has priority over all other transitions.
- Reset mid-operation: asynchronous return to reset values in the same cycle, including mid-WALK (walk_o drops immediately).
- Invariant: walk_o & dont_walk_o is never 1. walk_o=1 only while red_i=1 or on the single cycle after red falls.

Decomposition:
- Package ped_pkg:
  - ped_state_t enum logic [1:0]: IDLE=00, WALK=01, FLASH=10, FAULT=11.
  - Localparam defaults: WALK_CYCLES, FLASH_CYCLES, FLASH_HALF.
- Sub-module rise_detect: 1-bit registered rising-edge detector with async active-low reset, instanced for red_i and btn_i.

Test Plan:
1. Reset with red_i=1, no button; release reset -> walk_o=0, dont_walk_o=1, req_pending_o=0 indefinitely.
2. btn_i pulse during green -> req_pending_o=1 next cycle. On red_rise, walk_o=1 for exactly 8 cycles; then dont_walk_o sequence 1,0,1,0,1,0 with countdown_o 6,5,4,3,2,1; then solid dont_walk_o=1, countdown_o=0, req_pending_o=0.
3. btn_rise same cycle as red_rise, req_pending=0 -> walk_o=1 next cycle, req_pending_o never set.
4. Red drops after 3 WALK cycles -> walk_o=0, dont_walk_o=1 next cycle, state IDLE, req_pending_o=0.
5. btn pressed during FLASH -> req_pending_o=1 after FLASH ends; served at the next red_rise with full 8-cycle walk.
6. red_i=1 and green_i=1 for 1 cycle mid-WALK -> next cycle fault_o=1, walk_o=0, dont_walk_o=1. Remains so after inputs return legal, until rst_n is pulsed low.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared types and default timing for the pedestrian crossing controller.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WALK  = 2'b01,
    FLASH = 2'b10,
    FAULT = 2'b11
  } ped_state_t;

  localparam int WALK_CYCLES  = 8;
  localparam int FLASH_CYCLES = 6;
  localparam int FLASH_HALF   = 1;
  localparam int CNT_W        = 4;

  // The upstream light FSM must drive exactly one lamp at a time.
  function automatic logic lights_legal(input logic red, input logic yellow, input logic green);
    return (red & ~yellow & ~green) | (~red & yellow & ~green) | (~red & ~yellow & green);
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_rise_detect.sv
// Registered single-bit rising-edge detector.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // One-cycle delayed copy of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian walk/don't-walk controller slaved to the vehicle light FSM.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = ped_pkg::WALK_CYCLES,
  parameter int FLASH_CYCLES = ped_pkg::FLASH_CYCLES,
  parameter int FLASH_HALF   = ped_pkg::FLASH_HALF,
  parameter int CNT_W        = ped_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red_i,
  input  logic             yellow_i,
  input  logic             green_i,
  input  logic             btn_i,
  output logic             walk_o,
  output logic             dont_walk_o,
  output logic             req_pending_o,
  output logic [CNT_W-1:0] countdown_o,
  output logic             fault_o
);

  localparam int HALF_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CNT_W-1:0]  WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(FLASH_HALF - 1);

  ped_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              phase_q, phase_d;
  logic              req_q, req_d;
  logic              red_rise, btn_rise, lights_ok;

  rise_detect u_red_rise (.clk(clk), .rst_n(rst_n), .d(red_i), .rise(red_rise));
  rise_detect u_btn_rise (.clk(clk), .rst_n(rst_n), .d(btn_i), .rise(btn_rise));

  assign lights_ok = lights_legal(red_i, yellow_i, green_i);

  // Next-state, counter, flash phase and request latch.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    phase_d = phase_q;
    req_d   = req_q;
    if (!lights_ok || state_q == FAULT) begin
      // Illegal lamps win over everything and never clear without reset.
      state_d = FAULT;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (red_rise && (req_q || btn_rise)) begin
            state_d = WALK;
            req_d   = 1'b0;
            cnt_d   = WALK_LOAD;
          end else if (btn_rise) begin
            req_d = 1'b1;
          end
        end
        WALK: begin
          // Button presses here are absorbed by the walk being served.
          if (!red_i) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            state_d = FLASH;
            cnt_d   = FLASH_LOAD;
            phase_d = 1'b1;
            half_d  = HALF_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        FLASH: begin
          if (btn_rise) req_d = 1'b1;
          if (!red_i || cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (half_q == '0) begin
              phase_d = ~phase_q;
              half_d  = HALF_LOAD;
            end else begin
              half_d = half_q - 1'b1;
            end
          end
        end
        default: state_d = FAULT;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      phase_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      req_q   <= req_d;
    end
  end

  // Registered lamp and display outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk_o        <= 1'b0;
      dont_walk_o   <= 1'b1;
      req_pending_o <= 1'b0;
      countdown_o   <= '0;
      fault_o       <= 1'b0;
    end else begin
      walk_o        <= (state_d == WALK);
      dont_walk_o   <= (state_d == FLASH) ? phase_d : (state_d != WALK);
      req_pending_o <= req_d;
      countdown_o   <= (state_d == FLASH) ? cnt_d + 1'b1 : '0;
      fault_o       <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Randomised and directed bench for ped_crossing_ctrl against a timeline model.
module tb_ped_crossing_ctrl;

  localparam int WALK  = 8;
  localparam int FLASH = 6;
  localparam int HALF  = 1;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          red_i, yellow_i, green_i, btn_i;
  logic          walk_o, dont_walk_o, req_pending_o, fault_o;
  logic [CW-1:0] countdown_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a served request is a timeline indexed by cycles since walk start.
  bit m_fault, m_active, m_pend, m_prev_red, m_prev_btn;
  int m_elapsed;

  ped_crossing_ctrl #(
    .WALK_CYCLES(WALK), .FLASH_CYCLES(FLASH), .FLASH_HALF(HALF), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .red_i(red_i), .yellow_i(yellow_i), .green_i(green_i),
    .btn_i(btn_i), .walk_o(walk_o), .dont_walk_o(dont_walk_o),
    .req_pending_o(req_pending_o), .countdown_o(countdown_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fault = 0; m_active = 0; m_pend = 0; m_prev_red = 0; m_prev_btn = 0; m_elapsed = 0;
  endtask

  task automatic model_step(input bit r, input bit y, input bit g, input bit b);
    bit legal, rr, br;
    legal = (int'(r) + int'(y) + int'(g)) == 1;
    rr = r && !m_prev_red;
    br = b && !m_prev_btn;
    if (m_fault || !legal) begin
      m_fault = 1; m_active = 0; m_pend = 0;
    end else if (m_active) begin
      if (m_elapsed >= WALK && br) m_pend = 1;
      if (!r || m_elapsed == WALK + FLASH - 1) m_active = 0;
      else m_elapsed++;
    end else if (rr && (m_pend || br)) begin
      m_active = 1; m_elapsed = 0; m_pend = 0;
    end else if (br) begin
      m_pend = 1;
    end
    m_prev_red = r;
    m_prev_btn = b;
  endtask

  task automatic compare_outputs();
    bit ew, edw, ef;
    int ecd, k;
    ew = 0; edw = 1; ecd = 0; ef = m_fault;
    if (!m_fault && m_active) begin
      if (m_elapsed < WALK) begin
        ew = 1; edw = 0;
      end else begin
        k   = m_elapsed - WALK;
        edw = ((k / HALF) % 2) == 0;
        ecd = FLASH - k;
      end
    end
    check("walk_o", walk_o, ew);
    check("dont_walk_o", dont_walk_o, edw);
    check("req_pending_o", req_pending_o, m_pend);
    check("countdown_o", countdown_o, ecd);
    check("fault_o", fault_o, ef);
    check("lamp_overlap", walk_o & dont_walk_o, 0);
  endtask

  // One clock with fixed inputs; outputs checked on the falling edge.
  task automatic cycle(input bit r, input bit y, input bit g, input bit b);
    red_i = r; yellow_i = y; green_i = g; btn_i = b;
    @(posedge clk);
    model_step(r, y, g, b);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run(input bit r, input bit y, input bit g, input bit b, input int n);
    for (int i = 0; i < n; i++) cycle(r, y, g, b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    bit b;
    red_i = 1'b1; yellow_i = 1'b0; green_i = 1'b0; btn_i = 1'b0;

    // Reset held with red already on, then red steady with no button.
    do_reset();
    run(1, 0, 0, 0, 10);

    // Request latched during green, served on the next red edge.
    run(0, 0, 1, 0, 2);
    run(0, 0, 1, 1, 1);
    run(0, 0, 1, 0, 3);
    run(0, 1, 0, 0, 2);
    run(1, 0, 0, 0, 20);

    // Button rising on the same cycle as red.
    run(0, 0, 1, 0, 3);
    run(1, 0, 0, 1, 1);
    run(1, 0, 0, 0, 18);

    // Red lost after three walk cycles.
    run(0, 0, 1, 0, 2);
    run(1, 0, 0, 1, 1);
    run(1, 0, 0, 0, 3);
    run(0, 0, 1, 0, 4);

    // Press during flash, served on the following red phase.
    run(1, 0, 0, 0, 1);
    run(0, 0, 1, 0, 2);
    run(1, 0, 0, 1, 1);
    run(1, 0, 0, 0, 10);
    run(1, 0, 0, 1, 1);
    run(1, 0, 0, 0, 5);
    run(0, 0, 1, 0, 3);
    run(1, 0, 0, 0, 20);

    // Asynchronous reset mid-walk drops walk_o immediately.
    run(0, 0, 1, 0, 2);
    run(1, 0, 0, 1, 1);
    run(1, 0, 0, 0, 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 0, 0, 0, 3);

    // Random light phases with a wandering button level.
    b = 0;
    for (int i = 0; i < 30; i++) begin
      int gl, yl, rl;
      gl = $urandom_range(1, 6);
      yl = $urandom_range(1, 3);
      rl = $urandom_range(2, 22);
      for (int c = 0; c < gl + yl + rl; c++) begin
        if ($urandom_range(0, 3) == 0) b = ~b;
        if (c < gl)           cycle(0, 0, 1, b);
        else if (c < gl + yl) cycle(0, 1, 0, b);
        else                  cycle(1, 0, 0, b);
      end
    end

    // Illegal red+green mid-walk: sticky fault until reset.
    run(0, 0, 1, 0, 2);
    run(1, 0, 0, 1, 1);
    run(1, 0, 0, 0, 3);
    run(1, 0, 1, 0, 1);
    run(1, 0, 0, 0, 5);
    run(0, 0, 1, 1, 2);
    run(0, 0, 1, 0, 2);
    run(1, 0, 0, 0, 4);
    do_reset();
    run(0, 0, 1, 1, 2);
    run(1, 0, 0, 0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
